// File: rtl/vga_timing_gen.sv
// vga_timing_gen -- VGA raster timing generator.
//
// Walks a pixel position (h, v) across an H_TOTAL x V_TOTAL raster, one
// step per clk edge with pix_en=1, and produces sync, blanking and strobe
// signals for that position. Horizontal and vertical phases
// (ACTIVE/FRONT/SYNC/BACK) are tracked by small FSMs. Every output is
// registered on the same edge that moves the position, so all outputs
// describe the same pixel with no skew between them.
//
// Ports:
//   clk          in   system clock (only clock)
//   rst          in   synchronous active-high reset, priority over pix_en
//   pix_en       in   pixel-rate tick; position advances only when 1
//   hsync        out  horizontal sync, active-low
//   vsync        out  vertical sync, active-low
//   display_en   out  1 while the presented position is visible
//   pixel_x      out  [9:0] horizontal position (raw count)
//   pixel_y      out  [9:0] vertical position (raw count)
//   line_start   out  one-clk strobe when h becomes 0
//   frame_start  out  one-clk strobe when (h,v) becomes (0,0)
//   frame_count  out  [7:0] frames started since reset, modulo 256
//                     (present only when VGA_FRAME_COUNT_EN is defined)
//
// Optional feature macro: VGA_FRAME_COUNT_EN

module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pix_en,
    output logic       hsync,
    output logic       vsync,
    output logic       display_en,
    output logic [9:0] pixel_x,
    output logic [9:0] pixel_y,
    output logic       line_start,
    output logic       frame_start
`ifdef VGA_FRAME_COUNT_EN
    ,
    output logic [7:0] frame_count
`endif
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST        = 10'(H_TOTAL - 1);
    localparam logic [9:0] H_FRONT_START = 10'(H_ACTIVE);
    localparam logic [9:0] H_SYNC_START  = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_BACK_START  = 10'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [9:0] V_LAST        = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_FRONT_START = 10'(V_ACTIVE);
    localparam logic [9:0] V_SYNC_START  = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_BACK_START  = 10'(V_ACTIVE + V_FP + V_SYNC);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    phase_t     h_phase, v_phase;
    phase_t     h_phase_nxt, v_phase_nxt;
    logic [9:0] h, v;
    logic [9:0] h_nxt, v_nxt;
    logic       h_wrap, v_wrap;

    // Next position and next phases. Phases are looked ahead from the next
    // position so the registered outputs match the position being loaded.
    always_comb begin
        h_wrap = (h == H_LAST);
        v_wrap = (v == V_LAST);
        h_nxt  = h_wrap ? 10'd0 : h + 10'd1;
        v_nxt  = v;
        if (h_wrap) begin
            v_nxt = v_wrap ? 10'd0 : v + 10'd1;
        end

        h_phase_nxt = h_phase;
        case (h_phase)
            PH_ACTIVE: if (h_nxt == H_FRONT_START) h_phase_nxt = PH_FRONT;
            PH_FRONT:  if (h_nxt == H_SYNC_START)  h_phase_nxt = PH_SYNC;
            PH_SYNC:   if (h_nxt == H_BACK_START)  h_phase_nxt = PH_BACK;
            PH_BACK:   if (h_wrap)                 h_phase_nxt = PH_ACTIVE;
            default:                               h_phase_nxt = PH_BACK;
        endcase

        // The vertical FSM only moves on the edge that wraps h.
        v_phase_nxt = v_phase;
        if (h_wrap) begin
            case (v_phase)
                PH_ACTIVE: if (v_nxt == V_FRONT_START) v_phase_nxt = PH_FRONT;
                PH_FRONT:  if (v_nxt == V_SYNC_START)  v_phase_nxt = PH_SYNC;
                PH_SYNC:   if (v_nxt == V_BACK_START)  v_phase_nxt = PH_BACK;
                PH_BACK:   if (v_wrap)                 v_phase_nxt = PH_ACTIVE;
                default:                               v_phase_nxt = PH_BACK;
            endcase
        end
    end

    // Reset parks the position on the last pixel of the frame in BACK/BACK,
    // so the first pix_en edge afterwards lands on (0,0) with both strobes.
    always_ff @(posedge clk) begin
        if (rst) begin
            h           <= H_LAST;
            v           <= V_LAST;
            h_phase     <= PH_BACK;
            v_phase     <= PH_BACK;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            display_en  <= 1'b0;
            pixel_x     <= 10'd0;
            pixel_y     <= 10'd0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else if (pix_en) begin
            h           <= h_nxt;
            v           <= v_nxt;
            h_phase     <= h_phase_nxt;
            v_phase     <= v_phase_nxt;
            hsync       <= (h_phase_nxt != PH_SYNC);
            vsync       <= (v_phase_nxt != PH_SYNC);
            display_en  <= (h_phase_nxt == PH_ACTIVE) && (v_phase_nxt == PH_ACTIVE);
            pixel_x     <= h_nxt;
            pixel_y     <= v_nxt;
            line_start  <= h_wrap;
            frame_start <= h_wrap && v_wrap;
        end else begin
            // Strobes are single-clk even when pix_en is slower than clk.
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    // Counts on the same edge that raises frame_start.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_count <= 8'd0;
        end else if (pix_en && h_wrap && v_wrap) begin
            frame_count <= frame_count + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen -- directed bench for vga_timing_gen.
//
// Two instances share clk/rst/pix_en: one with the default 640x480 timing
// (used for reset release and single-line horizontal timing) and one with
// a reduced raster (20x10) so whole frames, decimated pix_en, mid-frame
// reset and the 257-frame counter run fit in a short simulation. The
// reduced instance is also followed every clk by a range-based reference
// model of the expected outputs.
//
// Ports: none (self-contained).

module tb_vga_timing_gen;

    // Reduced raster for the frame-level instance.
    localparam int S_HA = 10, S_HFP = 2, S_HS = 3, S_HBP = 5;
    localparam int S_VA = 4,  S_VFP = 1, S_VS = 2, S_VBP = 3;
    localparam int S_HT = S_HA + S_HFP + S_HS + S_HBP;   // 20
    localparam int S_VT = S_VA + S_VFP + S_VS + S_VBP;   // 10

    logic       clk;
    logic       rst;
    logic       pix_en;

    logic       f_hs, f_vs, f_de, f_ls, f_fs;
    logic [9:0] f_x, f_y;
    logic       s_hs, s_vs, s_de, s_ls, s_fs;
    logic [9:0] s_x, s_y;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] f_fc, s_fc;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int mm     = 0;

    // Reference model state for the reduced instance.
    int   mh, mv;
    logic e_hs, e_vs, e_de, e_ls, e_fs;
    int   e_x, e_y;

    vga_timing_gen dut_full (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hsync       (f_hs),
        .vsync       (f_vs),
        .display_en  (f_de),
        .pixel_x     (f_x),
        .pixel_y     (f_y),
        .line_start  (f_ls),
        .frame_start (f_fs)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count (f_fc)
`endif
    );

    vga_timing_gen #(
        .H_ACTIVE (S_HA), .H_FP (S_HFP), .H_SYNC (S_HS), .H_BP (S_HBP),
        .V_ACTIVE (S_VA), .V_FP (S_VFP), .V_SYNC (S_VS), .V_BP (S_VBP)
    ) dut_small (
        .clk         (clk),
        .rst         (rst),
        .pix_en      (pix_en),
        .hsync       (s_hs),
        .vsync       (s_vs),
        .display_en  (s_de),
        .pixel_x     (s_x),
        .pixel_y     (s_y),
        .line_start  (s_ls),
        .frame_start (s_fs)
`ifdef VGA_FRAME_COUNT_EN
        ,
        .frame_count (s_fc)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d, required %0d", tag, got, want);
        end
    endtask

    // Apply inputs, take one clk edge, sample 1 time unit later and step the
    // reference model with the inputs that the edge saw.
    task automatic tick(input logic r, input logic pe);
        rst    = r;
        pix_en = pe;
        @(posedge clk);
        #1;
        if (r) begin
            mh = S_HT - 1; mv = S_VT - 1;
            e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0;
            e_x = 0; e_y = 0; e_ls = 1'b0; e_fs = 1'b0;
        end else if (pe) begin
            if (mh == S_HT - 1) begin
                mh = 0;
                mv = (mv == S_VT - 1) ? 0 : mv + 1;
            end else begin
                mh = mh + 1;
            end
            e_x  = mh;
            e_y  = mv;
            e_hs = !(mh >= S_HA + S_HFP && mh < S_HA + S_HFP + S_HS);
            e_vs = !(mv >= S_VA + S_VFP && mv < S_VA + S_VFP + S_VS);
            e_de = (mh < S_HA) && (mv < S_VA);
            e_ls = (mh == 0);
            e_fs = (mh == 0) && (mv == 0);
        end else begin
            e_ls = 1'b0;
            e_fs = 1'b0;
        end
        if (s_hs !== e_hs || s_vs !== e_vs || s_de !== e_de || s_ls !== e_ls ||
            s_fs !== e_fs || int'(s_x) != e_x || int'(s_y) != e_y) begin
            mm++;
        end
    endtask

    initial begin
        int de_cnt, hs_cnt, hs_first, hs_last, ls_extra, fs_extra;
        int vs_low, vs_bad, de_late, first_fs, second_fs, odd_chg, wide;
        int fs_n;
        logic [9:0] prev_x;
        logic prev_ls, prev_fs;

        rst = 1'b1; pix_en = 1'b0;
        mh = S_HT - 1; mv = S_VT - 1;
        e_hs = 1'b1; e_vs = 1'b1; e_de = 1'b0; e_x = 0; e_y = 0;
        e_ls = 1'b0; e_fs = 1'b0;

        // Reset state and release on the 640x480 instance.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        chk("rst_hsync", f_hs, 1);
        chk("rst_vsync", f_vs, 1);
        chk("rst_display_en", f_de, 0);
        chk("rst_pixel_x", f_x, 0);
        chk("rst_pixel_y", f_y, 0);
        chk("rst_line_start", f_ls, 0);
        chk("rst_frame_start", f_fs, 0);

        de_cnt = 0; hs_cnt = 0; hs_first = -1; hs_last = -1;
        ls_extra = 0; fs_extra = 0;
        for (int i = 0; i < 800; i++) begin
            tick(1'b0, 1'b1);
            if (i == 0) begin
                chk("rel_pixel_x", f_x, 0);
                chk("rel_pixel_y", f_y, 0);
                chk("rel_display_en", f_de, 1);
                chk("rel_frame_start", f_fs, 1);
                chk("rel_line_start", f_ls, 1);
            end else begin
                if (f_ls) ls_extra++;
                if (f_fs) fs_extra++;
            end
            if (f_de) de_cnt++;
            if (!f_hs) begin
                hs_cnt++;
                if (hs_first < 0) hs_first = int'(f_x);
                hs_last = int'(f_x);
            end
        end
        chk("h_display_en_clks", de_cnt, 640);
        chk("h_hsync_low_clks", hs_cnt, 96);
        chk("h_hsync_first_x", hs_first, 656);
        chk("h_hsync_last_x", hs_last, 751);
        chk("h_line_start_inside_line", ls_extra, 0);
        chk("h_frame_start_inside_line", fs_extra, 0);
        tick(1'b0, 1'b1);
        chk("h_line_start_period", f_ls, 1);
        chk("h_next_line_x", f_x, 0);
        chk("h_next_line_y", f_y, 1);
        chk("h_next_line_fs", f_fs, 0);

        // Full frame on the reduced instance.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        vs_low = 0; vs_bad = 0; de_late = 0; de_cnt = 0; hs_cnt = 0; fs_extra = 0;
        for (int i = 0; i < S_HT * S_VT; i++) begin
            tick(1'b0, 1'b1);
            if (!s_vs) begin
                vs_low++;
                if (s_y < 10'(S_VA + S_VFP) || s_y >= 10'(S_VA + S_VFP + S_VS)) vs_bad++;
            end
            if (s_de) begin
                de_cnt++;
                if (s_y >= 10'(S_VA)) de_late++;
            end
            if (!s_hs) hs_cnt++;
            if (i > 0 && s_fs) fs_extra++;
        end
        chk("v_vsync_low_clks", vs_low, S_VS * S_HT);
        chk("v_vsync_wrong_line", vs_bad, 0);
        chk("v_display_en_late_line", de_late, 0);
        chk("v_display_en_clks", de_cnt, S_HA * S_VA);
        chk("v_hsync_low_clks", hs_cnt, S_HS * S_VT);
        chk("v_frame_start_inside", fs_extra, 0);
        tick(1'b0, 1'b1);
        chk("v_frame_start_period", s_fs, 1);
        chk("v_frame_wrap_y", s_y, 0);

        // pix_en on every second clk.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        first_fs = -1; second_fs = -1; odd_chg = 0; wide = 0;
        prev_x = s_x; prev_ls = 1'b0; prev_fs = 1'b0;
        for (int i = 0; i < 4 * S_HT * S_VT + 10; i++) begin
            tick(1'b0, (i % 2) == 0);
            if (s_fs) begin
                if (first_fs < 0) first_fs = i;
                else if (second_fs < 0) second_fs = i;
            end
            if ((i % 2) == 1 && s_x != prev_x) odd_chg++;
            if ((s_ls && prev_ls) || (s_fs && prev_fs)) wide++;
            prev_x = s_x; prev_ls = s_ls; prev_fs = s_fs;
        end
        chk("half_first_frame_start", first_fs, 0);
        chk("half_frame_period", second_fs - first_fs, 2 * S_HT * S_VT);
        chk("half_hold_on_idle_clk", odd_chg, 0);
        chk("half_strobe_width", wide, 0);

        // Reset in the middle of the visible area at (5,2).
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        for (int i = 0; i < 2 * S_HT + 6; i++) tick(1'b0, 1'b1);
        chk("mid_pos_x", s_x, 5);
        chk("mid_pos_y", s_y, 2);
        tick(1'b1, 1'b1);
        chk("mid_rst_hsync", s_hs, 1);
        chk("mid_rst_vsync", s_vs, 1);
        chk("mid_rst_display_en", s_de, 0);
        chk("mid_rst_pixel_x", s_x, 0);
        tick(1'b0, 1'b1);
        chk("mid_restart_x", s_x, 0);
        chk("mid_restart_y", s_y, 0);
        chk("mid_restart_de", s_de, 1);
        chk("mid_restart_fs", s_fs, 1);
        chk("mid_restart_ls", s_ls, 1);
        tick(1'b0, 1'b1);
        chk("mid_next_x", s_x, 1);
        chk("mid_next_fs", s_fs, 0);

`ifdef VGA_FRAME_COUNT_EN
        // 257 frames from reset on the reduced instance.
        for (int i = 0; i < 3; i++) tick(1'b1, 1'b0);
        chk("fc_reset", s_fc, 0);
        fs_n = 0;
        for (int i = 0; i < 257 * S_HT * S_VT + 10 && fs_n < 257; i++) begin
            tick(1'b0, 1'b1);
            if (s_fs) begin
                fs_n++;
                if (fs_n == 1) chk("fc_first_frame", s_fc, 1);
            end
        end
        chk("fc_frames_seen", fs_n, 257);
        chk("fc_after_257", s_fc, 1);
`else
        fs_n = 0;
`endif

        chk("model_mismatch_clks", mm, 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameters: H_ACTIVE 640 (visible pixels/line); H_FP 16 (front porch); H_SYNC 96 (sync width); H_BP 48 (back porch); V_ACTIVE 480 (visible lines); V_FP 10; V_SYNC 2; V_BP 33.
REQ-002 SHALL have port clk, input, 1, system clock; the only clock in the block.
REQ-003 SHALL have port rst, input, 1, reset, synchronous to clk, active-high.
REQ-004 SHALL have port pix_en, input, 1, pixel-rate tick; position advances only on clk edges where pix_en=1.
REQ-005 SHALL have port hsync, output, 1, horizontal sync, active-low.
REQ-006 SHALL have port vsync, output, 1, vertical sync, active-low.
REQ-007 SHALL have port display_en, output, 1, high while the presented position is visible; drives the enable input of the pixel colour stage.
REQ-008 SHALL have port pixel_x, output, 10, current horizontal position (raw count).
REQ-009 SHALL have port pixel_y, output, 10, current vertical position (raw count).
REQ-010 SHALL have port line_start, output, 1, one-clk strobe when a new line begins.
REQ-011 SHALL have port frame_start, output, 1, one-clk strobe when a new frame begins.

Function
REQ-012 SHALL hold position counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1), where H_TOTAL=sum of H params (800) and V_TOTAL=sum of V params (525).
REQ-013 SHALL, on a pix_en edge, advance h by 1; at h=H_TOTAL-1, wrap h to 0 and advance v; at v=V_TOTAL-1 with the h wrap, wrap v to 0.
REQ-014 SHALL run a horizontal phase FSM: ACTIVE (h 0..639), FRONT (640..655), SYNC (656..751), BACK (752..799), ACTIVE; each transition is taken on the pix_en edge that crosses its phase boundary.
REQ-015 SHALL run an equivalent vertical phase FSM: ACTIVE (v 0..479), FRONT (480..489), SYNC (490..491), BACK (492..524); it steps only on h wrap.
REQ-016 SHALL register all outputs on the same edge that updates the position, so that every output describes the new position with zero skew between them.
REQ-017 SHALL drive hsync=0 iff the H phase is SYNC, and vsync=0 iff the V phase is SYNC.
REQ-018 SHALL drive display_en=1 iff both phases are ACTIVE.
REQ-019 SHALL drive pixel_x=h and pixel_y=v, unmasked through the blanking intervals.
REQ-020 SHALL pulse line_start for exactly one clk when h becomes 0, and frame_start for exactly one clk when (h,v) becomes (0,0); both SHALL be 0 on all other cycles, including clk cycles with pix_en=0.
REQ-021 SHALL hold hsync, vsync, display_en, pixel_x and pixel_y unchanged on clk edges with pix_en=0.
REQ-022 SHALL NOT constrain pix_en duty: pix_en held at 1 gives one pixel per clk.

Reset
REQ-023 SHALL, while rst=1, set (h,v)=(H_TOTAL-1,V_TOTAL-1), the FSMs to BACK/BACK, hsync=1, vsync=1, display_en=0, pixel_x=0, pixel_y=0, line_start=0, frame_start=0.
REQ-024 SHALL give rst priority over pix_en; rst asserted mid-frame aborts the frame immediately.
REQ-025 SHALL present (0,0) on the first pix_en edge after rst deasserts, with display_en=1, line_start=1 and frame_start=1.

Configuration
REQ-026 SHALL, with VGA_FRAME_COUNT_EN defined, add output frame_count (8 bits), reset to 0, incrementing modulo 256 on every frame_start, including the first frame after reset.
REQ-027 SHALL, without VGA_FRAME_COUNT_EN, have neither the port frame_count nor its logic; all other behaviour is identical.

Verification
REQ-028 SHALL test reset release: rst for 3 clk, then pix_en=1 -> first output cycle has pixel_x=0, pixel_y=0, display_en=1, frame_start=1, line_start=1.
REQ-029 SHALL test horizontal timing: pix_en=1 for one line -> display_en high for 640 clk, hsync low for exactly 96 clk starting at pixel_x=656, line_start period of 800 clk.
REQ-030 SHALL test vertical timing: run one full frame -> vsync low on lines 490-491 only (1600 clk), display_en never high for pixel_y>=480, frame_start period of 420000 clk.
REQ-031 SHALL test pix_en=1 every 2nd clk -> outputs hold for 2 clk per position, strobes 1 clk wide, frame period of 840000 clk.
REQ-032 SHALL test mid-frame reset: rst at (h,v)=(300,200) -> next edge has hsync=1, vsync=1, display_en=0; restart from (0,0) per REQ-025.
REQ-033 SHALL test the frame counter with VGA_FRAME_COUNT_EN: run 257 frames from reset -> frame_count=1 after the 257th frame_start.
